oqpsk_half_sine_shaper: RTL and testbench
=========================================

Name: oqpsk_half_sine_shaper

Overview:
Transmit-side counterpart of the IQ demodulator front-end filter. It takes the 802.15.4 O-QPSK chip stream and produces 5-bit signed I/Q baseband samples with half-sine pulse shaping. Even chips go to the I rail and odd chips to the Q rail; Q is offset by one chip period (4 samples). The block sits between the chip spreader and the DAC/upconverter interface.

Parameters:
SAMPLE_DIV, 5, clk cycles per output sample (>=1); sample strobe every SAMPLE_DIV cycles while active

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
chip_in  in  1  chip value; 1 -> positive pulse, 0 -> negative pulse
chip_valid  in  1  chip_in/chip_last valid
chip_last  in  1  marks final chip of frame
chip_ready  out  1  chip accepted when chip_valid & chip_ready
i_out  out  5  signed I sample
q_out  out  5  signed Q sample
out_valid  out  1  one-cycle pulse per new i_out/q_out pair
busy  out  1  high from frame start until the last sample is emitted
err_underrun  out  1  sticky; chip missing at a required consumption point

Behaviour:
- Reset, clk/resetn: reset resetn, asynchronous, active-low; clock clk. Reset drives all outputs and state to 0: i_out=q_out=0, out_valid=0, busy=0, err_underrun=0, state IDLE, phase=0, div_cnt=0. Reset mid-frame aborts the frame immediately; nothing resumes after release.
- Pulse table, 8 samples per pulse (2 Tc), magnitude per index k=0..7: 3,8,12,15,15,12,8,3. Each sample is +mag for chip 1 and -mag for chip 0. An idle or ended rail outputs 0.
- FSM states:
  - IDLE: chip_ready=1; div_cnt held at 0. Acceptance moves to RUN (or FLUSH if chip_last=1), sets phase=0, loads the I chip and clears err_underrun.
  - RUN: chips are consumed.
  - FLUSH: no further consumption; outstanding pulses complete.
- Sample timing:
  - The first sample (phase 0) is registered in the cycle after acceptance: out_valid=1, i_out=+/-3, q_out=0.
  - Later samples are produced on each strobe (div_cnt==SAMPLE_DIV-1); div_cnt wraps to 0 on the strobe.
  - phase is a 3-bit counter that increments per sample and wraps 7->0.
  - I index = phase; Q index = phase-4 mod 8. The Q rail outputs 0 until the first Q chip starts.
- Consumption in RUN:
  - chip_ready = strobe & (next phase == 4 or next phase == 0). It depends only on state and counters, never on chip_valid.
  - Next phase 4 loads a Q chip; next phase 0 loads an I chip.
  - The accepted chip's first sample appears on the same output update.
- Frame end:
  - Accepting a chip with chip_last=1 moves the FSM to FLUSH.
  - In FLUSH, the rail whose next pulse would start outputs 0.
  - After the last chip's index-7 sample, the FSM returns to IDLE and busy drops the next cycle.
  - A frame of N chips emits exactly 4N+4 out_valid pulses.
- Underrun:
  - chip_ready=1 in RUN with chip_valid=0 sets err_underrun.
  - That rail emits an all-zero pulse; the frame continues and the next consumption point proceeds normally.
- Simultaneous events: in IDLE, acceptance and strobe cannot coincide (div_cnt is held). A chip_last chip accepted from IDLE is a 1-chip frame of 8 samples.
- Widths: table values are unsigned 4-bit. Negation and output are 5-bit two's complement, with range -15..+15 and no saturation needed.

Optional Feature:
SHAPER_GAIN_EN
- Defined: adds input gain_sel[1:0]. Both rails output the signed table sample arithmetic-shifted right by gain_sel. gain_sel is sampled at frame start and held for the frame.
- Undefined: no gain_sel port; full-scale output.

Test Plan:
1. SAMPLE_DIV=1, single chip 1 with last=1 -> i_out 3,8,12,15,15,12,8,3 on 8 consecutive out_valid; q_out=0; busy falls after the 8th; err_underrun=0.
2. SAMPLE_DIV=1, chips 1,0 (last on 2nd) -> 12 samples. I = 3,8,12,15,15,12,8,3,0,0,0,0. Q = 0,0,0,0,-3,-8,-12,-15,-15,-12,-8,-3.
3. SAMPLE_DIV=5, 32 chips alternating 1/0, chip_valid held high -> out_valid every 5 cycles, chip_ready one cycle per 20, 132 samples, no underrun.
4. 8-chip frame with chip_valid dropped at the 4th chip's consumption point -> err_underrun=1 and sticky; 4th chip's Q pulse all 0; chips 5-8 shaped normally. A new frame clears the flag.
5. Assert resetn low mid-frame (sample 10) -> all outputs 0 asynchronously. After release, a new 1-chip frame produces test 1's sequence.
6. SHAPER_GAIN_EN, gain_sel=2, chip 0 -> i_out -1,-2,-3,-4,-4,-3,-2,-1; chip 1 -> 0,2,3,3,3,3,2,0.

Source files
------------

// File: rtl/oqpsk_half_sine_shaper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oqpsk_half_sine_shaper: O-QPSK chips -> half-sine shaped 5-bit I/Q.      |
// | Optional macro SHAPER_GAIN_EN adds a per-frame gain_sel right shift.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module oqpsk_half_sine_shaper #(
  parameter int SAMPLE_DIV = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              chip_in,
  input  logic              chip_valid,
  input  logic              chip_last,
`ifdef SHAPER_GAIN_EN
  input  logic [1:0]        gain_sel,
`endif
  output logic              chip_ready,
  output logic signed [4:0] i_out,
  output logic signed [4:0] q_out,
  output logic              out_valid,
  output logic              busy,
  output logic              err_underrun
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_phase, w_phase_nxt, w_phase_inc;
  logic [DIV_W-1:0]  r_div_cnt, w_div_nxt;
  logic              r_i_on, r_i_chip, r_q_on, r_q_chip, r_last_q, r_err;
  logic              w_i_on, w_i_chip, w_q_on, w_q_chip, w_last_q, w_err;
  logic              r_out_valid, w_emit;
  logic signed [4:0] r_i_out, r_q_out, w_i_out, w_q_out;
  logic [1:0]        w_gain;
  logic              w_strobe, w_end;

  function automatic logic signed [4:0] shape(input logic on, input logic chip,
                                              input logic [2:0] k, input logic [1:0] sh);
    logic [3:0]        mag;
    logic signed [4:0] s;
    case (k)
      3'd0, 3'd7: mag = 4'd3;
      3'd1, 3'd6: mag = 4'd8;
      3'd2, 3'd5: mag = 4'd12;
      default:    mag = 4'd15;
    endcase
    s = $signed({1'b0, mag});
    if (!chip) s = -s;
    if (!on)   s = '0;
    return s >>> sh;
  endfunction

`ifdef SHAPER_GAIN_EN
  logic [1:0] r_gain;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                r_gain <= 2'd0;
    else if (r_state == ST_IDLE && chip_valid)  r_gain <= gain_sel;
  end
  assign w_gain = (r_state == ST_IDLE) ? gain_sel : r_gain;
`else
  assign w_gain = 2'd0;
`endif

  assign w_phase_inc = r_phase + 3'd1;
  assign w_strobe    = (r_state != ST_IDLE) && (r_div_cnt == C_DIV_LAST);
  // The frame's final sample is the last chip's index 7: phase 7 on I, phase 3 on Q.
  assign w_end       = (r_state == ST_FLUSH) && (r_phase == (r_last_q ? 3'd3 : 3'd7));
  assign chip_ready  = (r_state == ST_IDLE) ||
                       ((r_state == ST_RUN) && w_strobe && (w_phase_inc[1:0] == 2'b00));

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_div_nxt   = r_div_cnt;
    w_i_on      = r_i_on;
    w_i_chip    = r_i_chip;
    w_q_on      = r_q_on;
    w_q_chip    = r_q_chip;
    w_last_q    = r_last_q;
    w_err       = r_err;
    w_emit      = 1'b0;
    w_i_out     = r_i_out;
    w_q_out     = r_q_out;
    case (r_state)
      ST_IDLE: begin
        w_div_nxt = '0;
        if (chip_valid) begin
          w_state_nxt = chip_last ? ST_FLUSH : ST_RUN;
          w_phase_nxt = 3'd0;
          w_i_on      = 1'b1;
          w_i_chip    = chip_in;
          w_q_on      = 1'b0;
          w_last_q    = 1'b0;
          w_err       = 1'b0;
          w_emit      = 1'b1;
        end
      end
      default: begin
        if (w_end) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = 3'd0;
          w_div_nxt   = '0;
          w_i_on      = 1'b0;
          w_q_on      = 1'b0;
        end else if (w_strobe) begin
          w_div_nxt   = '0;
          w_phase_nxt = w_phase_inc;
          w_emit      = 1'b1;
          // Phase 4 starts a Q pulse, phase 0 an I pulse; a missing chip yields a zero pulse.
          if (w_phase_inc[1:0] == 2'b00) begin
            if (r_state == ST_RUN) begin
              if (!chip_valid) begin
                w_err = 1'b1;
              end else if (chip_last) begin
                w_state_nxt = ST_FLUSH;
                w_last_q    = w_phase_inc[2];
              end
              if (w_phase_inc[2]) begin
                w_q_on   = chip_valid;
                w_q_chip = chip_in;
              end else begin
                w_i_on   = chip_valid;
                w_i_chip = chip_in;
              end
            end else if (w_phase_inc[2]) begin
              w_q_on = 1'b0;
            end else begin
              w_i_on = 1'b0;
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end
    endcase
    if (w_emit) begin
      w_i_out = shape(w_i_on, w_i_chip, w_phase_nxt, w_gain);
      w_q_out = shape(w_q_on, w_q_chip, {~w_phase_nxt[2], w_phase_nxt[1:0]}, w_gain);
    end else if (w_end) begin
      w_i_out = '0;
      w_q_out = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_phase     <= 3'd0;
      r_div_cnt   <= '0;
      r_i_on      <= 1'b0;
      r_i_chip    <= 1'b0;
      r_q_on      <= 1'b0;
      r_q_chip    <= 1'b0;
      r_last_q    <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_i_out     <= '0;
      r_q_out     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_div_cnt   <= w_div_nxt;
      r_i_on      <= w_i_on;
      r_i_chip    <= w_i_chip;
      r_q_on      <= w_q_on;
      r_q_chip    <= w_q_chip;
      r_last_q    <= w_last_q;
      r_err       <= w_err;
      r_out_valid <= w_emit;
      r_i_out     <= w_i_out;
      r_q_out     <= w_q_out;
    end
  end

  assign i_out        = r_i_out;
  assign q_out        = r_q_out;
  assign out_valid    = r_out_valid;
  assign busy         = (r_state != ST_IDLE);
  assign err_underrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_oqpsk_half_sine_shaper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_oqpsk_half_sine_shaper: self-checking bench for the half-sine shaper. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_oqpsk_half_sine_shaper;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic chip_in = 1'b0, chip_valid = 1'b0, chip_last = 1'b0;
  logic sel = 1'b0;
`ifdef SHAPER_GAIN_EN
  logic [1:0] gain_sel = 2'd0;
`endif

  logic rdy1, ov1, busy1, err1, rdy5, ov5, busy5, err5;
  logic signed [4:0] i1, q1, i5, q5;
  logic chip_ready, out_valid, busy, err_underrun;
  logic signed [4:0] i_out, q_out;

  always #5 clk = ~clk;

  oqpsk_half_sine_shaper #(.SAMPLE_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .chip_in(chip_in),
    .chip_valid(chip_valid & ~sel), .chip_last(chip_last),
`ifdef SHAPER_GAIN_EN
    .gain_sel(gain_sel),
`endif
    .chip_ready(rdy1), .i_out(i1), .q_out(q1), .out_valid(ov1),
    .busy(busy1), .err_underrun(err1)
  );

  oqpsk_half_sine_shaper #(.SAMPLE_DIV(5)) u_dut5 (
    .clk(clk), .resetn(resetn), .chip_in(chip_in),
    .chip_valid(chip_valid & sel), .chip_last(chip_last),
`ifdef SHAPER_GAIN_EN
    .gain_sel(gain_sel),
`endif
    .chip_ready(rdy5), .i_out(i5), .q_out(q5), .out_valid(ov5),
    .busy(busy5), .err_underrun(err5)
  );

  assign chip_ready   = sel ? rdy5  : rdy1;
  assign out_valid    = sel ? ov5   : ov1;
  assign busy         = sel ? busy5 : busy1;
  assign err_underrun = sel ? err5  : err1;
  assign i_out        = sel ? i5    : i1;
  assign q_out        = sel ? q5    : q1;

  int errors = 0, checks = 0;
  int cyc = 0, last_ov_cyc = 0, n_seen = 0, expect_total = 0, nslots = 0, div_cur = 1;
  int exp_i[$], exp_q[$];
  int slot_val[64];  // per consumption slot: +1 chip 1, -1 chip 0, 0 missing chip
  int mag_t[8]     = '{3, 8, 12, 15, 15, 12, 8, 3};
  int pulse_lit[8] = '{3, 8, 12, 15, 15, 12, 8, 3};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot s starts its pulse at sample 4s; even slots on I, odd slots on Q.
  task automatic build_model(input int gain);
    int iv, qv;
    exp_i.delete();
    exp_q.delete();
    expect_total = 4 * nslots + 4;
    for (int n = 0; n < expect_total; n++) begin
      iv = 0;
      qv = 0;
      for (int s = 0; s < nslots; s++) begin
        if (n >= 4 * s && n < 4 * s + 8) begin
          if (s % 2 == 0) iv += mag_t[n - 4 * s] * slot_val[s];
          else            qv += mag_t[n - 4 * s] * slot_val[s];
        end
      end
      exp_i.push_back(iv >>> gain);
      exp_q.push_back(qv >>> gain);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (exp_i.size() == 0) begin
        check("sample_overrun", n_seen + 1, expect_total);
      end else begin
        check("i_out", i_out, exp_i.pop_front());
        check("q_out", q_out, exp_q.pop_front());
      end
      if (n_seen > 0) check("sample_gap", cyc - last_ov_cyc, sel ? 5 : 1);
      last_ov_cyc = cyc;
      n_seen++;
    end
  end

  task automatic run_frame();
    int s, budget, prev_rdy, hole;
    s = 0; budget = 0; prev_rdy = -1; hole = 0; n_seen = 0;
    for (int k = 0; k < nslots; k++) if (slot_val[k] == 0) hole = 1;
    while (s < nslots && budget < 4000) begin
      @(negedge clk);
      budget++;
      chip_valid = (slot_val[s] != 0);
      chip_in    = (slot_val[s] > 0);
      chip_last  = (s == nslots - 1);
      if (chip_ready) begin
        if (busy) begin
          if (prev_rdy >= 0) check("ready_period", cyc - prev_rdy, 4 * div_cur);
          prev_rdy = cyc;
        end
        s++;
      end
    end
    @(negedge clk);
    chip_valid = 1'b0;
    chip_last  = 1'b0;
    while (n_seen < expect_total && budget < 4000) begin
      @(negedge clk); #1;
      budget++;
    end
    check("frame_samples", n_seen, expect_total);
    check("busy_at_last", busy, 1);
    @(negedge clk); #1;
    check("busy_after", busy, 0);
    check("err_underrun", err_underrun, hole);
    repeat (2 * div_cur + 2) @(negedge clk);
    check("no_extra", n_seen, expect_total);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    #3 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_underrun, 0);
    check("rst_chip_ready", chip_ready, 1);
    @(negedge clk) resetn = 1'b1;

    // Single chip frame, SAMPLE_DIV=1
    sel = 1'b0; div_cur = 1;
    nslots = 1; slot_val[0] = 1;
    build_model(0);
    for (int k = 0; k < 8; k++) check("model_pulse", exp_i[k], pulse_lit[k]);
    run_frame();

    // Chips 1,0
    nslots = 2; slot_val[0] = 1; slot_val[1] = -1;
    build_model(0);
    check("model_t2_total", expect_total, 12);
    check("model_t2_q4", exp_q[4], -3);
    check("model_t2_i8", exp_i[8], 0);
    run_frame();

    // 32 alternating chips, SAMPLE_DIV=5
    sel = 1'b1; div_cur = 5;
    nslots = 32;
    for (int k = 0; k < 32; k++) slot_val[k] = (k % 2 == 0) ? 1 : -1;
    build_model(0);
    check("model_t3_total", expect_total, 132);
    run_frame();

    // Underrun at the 4th consumption point; chip 4 moves to the next slot
    sel = 1'b0; div_cur = 1;
    nslots = 9;
    slot_val[0] = 1;  slot_val[1] = -1; slot_val[2] = 1;  slot_val[3] = 0;
    slot_val[4] = -1; slot_val[5] = 1;  slot_val[6] = -1; slot_val[7] = 1;
    slot_val[8] = -1;
    build_model(0);
    check("model_t4_q12", exp_q[12], 0);
    check("model_t4_q16", exp_q[16], 0);
    check("model_t4_i16", exp_i[16], -3);
    run_frame();
    repeat (5) @(negedge clk);
    check("err_sticky", err_underrun, 1);
    nslots = 1; slot_val[0] = 1;
    build_model(0);
    run_frame();

    // Reset mid-frame at sample 10
    nslots = 20;
    for (int k = 0; k < 20; k++) slot_val[k] = 1;
    build_model(0);
    n_seen = 0; budget = 0;
    @(negedge clk);
    chip_valid = 1'b1; chip_in = 1'b1; chip_last = 1'b0;
    while (n_seen < 10 && budget < 1000) begin
      @(negedge clk); #1;
      budget++;
    end
    check("pre_reset_samples", n_seen, 10);
    #2 resetn = 1'b0;
    #1;
    check("async_i_out", i_out, 0);
    check("async_q_out", q_out, 0);
    check("async_out_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_err", err_underrun, 0);
    chip_valid = 1'b0;
    exp_i.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", busy, 0);
    nslots = 1; slot_val[0] = 1;
    build_model(0);
    run_frame();

`ifdef SHAPER_GAIN_EN
    gain_sel = 2'd2;
    nslots = 1; slot_val[0] = -1;
    build_model(2);
    check("model_gain_neg0", exp_i[0], -1);
    check("model_gain_neg3", exp_i[3], -4);
    run_frame();
    slot_val[0] = 1;
    build_model(2);
    check("model_gain_pos0", exp_i[0], 0);
    check("model_gain_pos1", exp_i[1], 2);
    run_frame();
    gain_sel = 2'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
